// File: rtl/rvfpga_axi_arb_pkg.sv
// Shared types for the two-master AXI RAM arbiter.
//  wr_state_t / rd_state_t : per-direction burst FSM states
//  RESP_*                  : AXI response encodings seen on B/R
//  rr_pick()               : 2-way round-robin selection
package rvfpga_axi_arb_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A lone requester always wins; on a tie the pointer names the preferred master.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    case (req)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ptr;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with registered grant.
//  req_i     : request from master 0 (bit 0) and master 1 (bit 1)
//  load_i    : capture a new grant from req_i (arbiter idle and some request present)
//  advance_i : current burst finished; the other master becomes preferred on the next tie
//  gnt_o     : index of the master currently / last granted
module rr_arb2
  import rvfpga_axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       load_i,
  input  logic       advance_i,
  output logic       gnt_o
);

  logic gnt_q, gnt_d;
  logic ptr_q, ptr_d;   // 0: master 0 preferred on a tie

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (load_i)    gnt_d = rr_pick(req_i, ptr_q);
    if (advance_i) ptr_d = ~gnt_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_q <= 1'b0;
      ptr_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/axi_ram_arbiter2.sv
// Two-master to one-slave AXI4 arbiter in front of axi_ram.
//  s0_* / s1_* : AXI4 slave-side bundles from the core port and a second master
//  m_*         : AXI4 master-side bundle to the RAM
//  o_wr_gnt / o_rd_gnt   : master currently / last granted per direction
//  o_wr_busy / o_rd_busy : direction FSM not idle
// Writes and reads are arbitrated independently; one burst per direction in flight,
// grant re-decided only after the burst (B handshake / last R beat) completes.
module axi_ram_arbiter2
  import rvfpga_axi_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master 0
  input  logic [ID_WIDTH-1:0]     s0_awid,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [7:0]              s0_awlen,
  input  logic [2:0]              s0_awsize,
  input  logic [1:0]              s0_awburst,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wlast,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [ID_WIDTH-1:0]     s0_bid,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  input  logic [ID_WIDTH-1:0]     s0_arid,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [7:0]              s0_arlen,
  input  logic [2:0]              s0_arsize,
  input  logic [1:0]              s0_arburst,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [ID_WIDTH-1:0]     s0_rid,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rlast,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  // master 1
  input  logic [ID_WIDTH-1:0]     s1_awid,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [7:0]              s1_awlen,
  input  logic [2:0]              s1_awsize,
  input  logic [1:0]              s1_awburst,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wlast,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [ID_WIDTH-1:0]     s1_bid,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  input  logic [ID_WIDTH-1:0]     s1_arid,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [7:0]              s1_arlen,
  input  logic [2:0]              s1_arsize,
  input  logic [1:0]              s1_arburst,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [ID_WIDTH-1:0]     s1_rid,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rlast,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  // slave (axi_ram)
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // debug
  output logic                    o_wr_gnt,
  output logic                    o_rd_gnt,
  output logic                    o_wr_busy,
  output logic                    o_rd_busy
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic      wr_gnt, wr_load, wr_adv;
  logic      rd_gnt, rd_load, rd_adv;

  rr_arb2 u_wr_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     ({s1_awvalid, s0_awvalid}),
    .load_i    (wr_load),
    .advance_i (wr_adv),
    .gnt_o     (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     ({s1_arvalid, s0_arvalid}),
    .load_i    (rd_load),
    .advance_i (rd_adv),
    .gnt_o     (rd_gnt)
  );

  // Payload muxes follow the grant unconditionally; only valid/ready are state-gated.
  assign m_awid    = wr_gnt ? s1_awid    : s0_awid;
  assign m_awaddr  = wr_gnt ? s1_awaddr  : s0_awaddr;
  assign m_awlen   = wr_gnt ? s1_awlen   : s0_awlen;
  assign m_awsize  = wr_gnt ? s1_awsize  : s0_awsize;
  assign m_awburst = wr_gnt ? s1_awburst : s0_awburst;
  assign m_wdata   = wr_gnt ? s1_wdata   : s0_wdata;
  assign m_wstrb   = wr_gnt ? s1_wstrb   : s0_wstrb;
  assign m_wlast   = wr_gnt ? s1_wlast   : s0_wlast;
  assign m_arid    = rd_gnt ? s1_arid    : s0_arid;
  assign m_araddr  = rd_gnt ? s1_araddr  : s0_araddr;
  assign m_arlen   = rd_gnt ? s1_arlen   : s0_arlen;
  assign m_arsize  = rd_gnt ? s1_arsize  : s0_arsize;
  assign m_arburst = rd_gnt ? s1_arburst : s0_arburst;

  assign s0_bid   = m_bid;
  assign s1_bid   = m_bid;
  assign s0_bresp = m_bresp;
  assign s1_bresp = m_bresp;
  assign s0_rid   = m_rid;
  assign s1_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_load    = 1'b0;
    wr_adv     = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (s0_awvalid || s1_awvalid) begin
          wr_load    = 1'b1;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid  = wr_gnt ? s1_awvalid : s0_awvalid;
        s0_awready = !wr_gnt && m_awready;
        s1_awready =  wr_gnt && m_awready;
        if (m_awvalid && m_awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        m_wvalid  = wr_gnt ? s1_wvalid : s0_wvalid;
        s0_wready = !wr_gnt && m_wready;
        s1_wready =  wr_gnt && m_wready;
        if (m_wvalid && m_wready && m_wlast) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_bready  = wr_gnt ? s1_bready : s0_bready;
        s0_bvalid = !wr_gnt && m_bvalid;
        s1_bvalid =  wr_gnt && m_bvalid;
        if (m_bvalid && m_bready) begin
          wr_adv     = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_load    = 1'b0;
    rd_adv     = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          rd_load    = 1'b1;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid  = rd_gnt ? s1_arvalid : s0_arvalid;
        s0_arready = !rd_gnt && m_arready;
        s1_arready =  rd_gnt && m_arready;
        if (m_arvalid && m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_rready  = rd_gnt ? s1_rready : s0_rready;
        s0_rvalid = !rd_gnt && m_rvalid;
        s1_rvalid =  rd_gnt && m_rvalid;
        if (m_rvalid && m_rready && m_rlast) begin
          rd_adv     = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Reset abandons any in-flight burst; all handshake outputs decode from state, so they drop with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign o_wr_gnt  = wr_gnt;
  assign o_rd_gnt  = rd_gnt;
  assign o_wr_busy = (wr_state_q != W_IDLE);
  assign o_rd_busy = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_ram_arbiter2.sv
// Bench for axi_ram_arbiter2: two master BFMs, a behavioural AXI RAM slave,
// a reference memory and per-master read-data scoreboards.
module tb_axi_ram_arbiter2;
  import rvfpga_axi_arb_pkg::*;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // master-side signals, index = master number
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [5:0]  s_awid [2], s_arid [2], s_bid [2], s_rid [2];
  logic [31:0] s_awaddr [2], s_araddr [2];
  logic [7:0]  s_awlen [2], s_arlen [2], s_wstrb [2];
  logic [2:0]  s_awsize [2], s_arsize [2];
  logic [1:0]  s_awburst [2], s_arburst [2], s_bresp [2], s_rresp [2];
  logic [63:0] s_wdata [2], s_rdata [2];

  logic [5:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen, m_wstrb;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [63:0] m_wdata, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic        o_wr_gnt, o_rd_gnt, o_wr_busy, o_rd_busy;

  axi_ram_arbiter2 dut (
    .clk(clk), .rstn(rstn),
    .s0_awid(s_awid[0]), .s0_awaddr(s_awaddr[0]), .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]),
    .s0_awburst(s_awburst[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]), .s0_wvalid(s_wvalid[0]),
    .s0_wready(s_wready[0]), .s0_bid(s_bid[0]), .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]),
    .s0_bready(s_bready[0]), .s0_arid(s_arid[0]), .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]),
    .s0_arsize(s_arsize[0]), .s0_arburst(s_arburst[0]), .s0_arvalid(s_arvalid[0]),
    .s0_arready(s_arready[0]), .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s0_rlast(s_rlast[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s1_awid(s_awid[1]), .s1_awaddr(s_awaddr[1]), .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]),
    .s1_awburst(s_awburst[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]), .s1_wvalid(s_wvalid[1]),
    .s1_wready(s_wready[1]), .s1_bid(s_bid[1]), .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]),
    .s1_bready(s_bready[1]), .s1_arid(s_arid[1]), .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]),
    .s1_arsize(s_arsize[1]), .s1_arburst(s_arburst[1]), .s1_arvalid(s_arvalid[1]),
    .s1_arready(s_arready[1]), .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .s1_rlast(s_rlast[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .o_wr_gnt(o_wr_gnt), .o_rd_gnt(o_rd_gnt), .o_wr_busy(o_wr_busy), .o_rd_busy(o_rd_busy)
  );

  // ---------------- behavioural AXI RAM slave ----------------
  logic [63:0] ram [0:8191];
  logic [1:0]  sw_st;
  logic [12:0] sw_idx, sr_idx;
  logic [7:0]  sw_len, sw_cnt, sr_len, sr_cnt;
  logic        sr_st;
  int          slave_err = 0;

  assign m_awready = (sw_st == 2'd0);
  assign m_wready  = (sw_st == 2'd1);
  assign m_bvalid  = (sw_st == 2'd2);
  assign m_bresp   = RESP_OKAY;
  assign m_arready = !sr_st;
  assign m_rvalid  = sr_st;
  assign m_rdata   = ram[sr_idx];
  assign m_rlast   = (sr_cnt == sr_len);
  assign m_rresp   = RESP_OKAY;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_st <= 2'd0;
    end else begin
      case (sw_st)
        2'd0: if (m_awvalid) begin
          sw_idx <= m_awaddr[15:3];
          m_bid  <= m_awid;
          sw_len <= m_awlen;
          sw_cnt <= 8'd0;
          if (m_awsize != 3'd3 || m_awburst != 2'd1) slave_err <= slave_err + 1;
          sw_st  <= 2'd1;
        end
        2'd1: if (m_wvalid) begin
          for (int b = 0; b < 8; b++)
            if (m_wstrb[b]) ram[sw_idx][8*b +: 8] <= m_wdata[8*b +: 8];
          sw_idx <= sw_idx + 13'd1;
          sw_cnt <= sw_cnt + 8'd1;
          if (m_wlast) begin
            if (sw_cnt != sw_len) slave_err <= slave_err + 1;
            sw_st <= 2'd2;
          end
        end
        default: if (m_bready) sw_st <= 2'd0;
      endcase
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_st <= 1'b0;
    end else if (!sr_st) begin
      if (m_arvalid) begin
        sr_idx <= m_araddr[15:3];
        m_rid  <= m_arid;
        sr_len <= m_arlen;
        sr_cnt <= 8'd0;
        if (m_arsize != 3'd3 || m_arburst != 2'd1) slave_err <= slave_err + 1;
        sr_st  <= 1'b1;
      end
    end else if (m_rready) begin
      sr_idx <= sr_idx + 13'd1;
      sr_cnt <= sr_cnt + 8'd1;
      if (m_rlast) sr_st <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic wr_busy_p = 1'b0, rd_busy_p = 1'b0;
  logic wr_log [$], rd_log [$];
  int   overlap_cnt = 0, leak_cnt = 0, s1_act_cnt = 0;

  always @(negedge clk) begin
    wr_busy_p <= o_wr_busy;
    rd_busy_p <= o_rd_busy;
    if (o_wr_busy && !wr_busy_p) wr_log.push_back(o_wr_gnt);
    if (o_rd_busy && !rd_busy_p) rd_log.push_back(o_rd_gnt);
    if (o_wr_busy && o_rd_busy) overlap_cnt <= overlap_cnt + 1;
    if (|{s_awready[!o_wr_gnt], s_wready[!o_wr_gnt], s_bvalid[!o_wr_gnt],
          s_arready[!o_rd_gnt], s_rvalid[!o_rd_gnt]})
      leak_cnt <= leak_cnt + 1;
    if (|{s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]})
      s1_act_cnt <= s1_act_cnt + 1;
  end

  // ---------------- checking infrastructure ----------------
  int tests = 0, fails = 0;
  logic [63:0] mdl [int];
  logic [63:0] exp_q0 [$], exp_q1 [$];
  logic wr_pref = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  function automatic logic [18:0] ctl_vec();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_awready, s_wready, s_bvalid,
            s_arready, s_rvalid, o_wr_busy, o_rd_busy, o_wr_gnt, o_rd_gnt};
  endfunction

  task automatic do_write(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [63:0] base, input logic [7:0] strb, input logic [5:0] id);
    int n;
    int idx;
    logic [63:0] d;
    s_awid[m] = id; s_awaddr[m] = addr; s_awlen[m] = len; s_awsize[m] = 3'd3; s_awburst[m] = 2'd1;
    s_awvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready[m] && n < TMO);
    if (!s_awready[m]) begin timeout($sformatf("aw m%0d", m)); s_awvalid[m] = 1'b0; return; end
    @(posedge clk); #1 s_awvalid[m] = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      d = base * 64'(k + 1);
      s_wdata[m] = d; s_wstrb[m] = strb; s_wlast[m] = (k == int'(len)); s_wvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_wready[m] && n < TMO);
      if (!s_wready[m]) begin timeout($sformatf("w m%0d", m)); s_wvalid[m] = 1'b0; return; end
      @(posedge clk); #1 s_wvalid[m] = 1'b0; s_wlast[m] = 1'b0;
      idx = int'(addr >> 3) + k;
      if (!mdl.exists(idx)) mdl[idx] = 64'h0;
      for (int b = 0; b < 8; b++) if (strb[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
    s_bready[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid[m] && n < TMO);
    if (!s_bvalid[m]) begin timeout($sformatf("b m%0d", m)); s_bready[m] = 1'b0; return; end
    check($sformatf("bresp m%0d", m), 64'(s_bresp[m]), 64'(RESP_OKAY));
    check($sformatf("bid m%0d", m), 64'(s_bid[m]), 64'(id));
    @(posedge clk); #1 s_bready[m] = 1'b0;
    wr_pref = (m == 0);
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input logic [5:0] id);
    int n;
    logic [63:0] e;
    for (int k = 0; k <= int'(len); k++) begin
      if (m == 0) exp_q0.push_back(mdl[int'(addr >> 3) + k]);
      else        exp_q1.push_back(mdl[int'(addr >> 3) + k]);
    end
    s_arid[m] = id; s_araddr[m] = addr; s_arlen[m] = len; s_arsize[m] = 3'd3; s_arburst[m] = 2'd1;
    s_arvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready[m] && n < TMO);
    if (!s_arready[m]) begin timeout($sformatf("ar m%0d", m)); s_arvalid[m] = 1'b0; return; end
    @(posedge clk); #1 s_arvalid[m] = 1'b0; s_rready[m] = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!s_rvalid[m] && n < TMO);
      if (!s_rvalid[m]) begin timeout($sformatf("r m%0d", m)); s_rready[m] = 1'b0; return; end
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rdata m%0d beat %0d", m, k), s_rdata[m], e);
      check($sformatf("rid m%0d", m), 64'(s_rid[m]), 64'(id));
      check($sformatf("rlast m%0d beat %0d", m, k), 64'(s_rlast[m]), 64'(k == int'(len)));
      check($sformatf("rresp m%0d", m), 64'(s_rresp[m]), 64'(RESP_OKAY));
      @(posedge clk); #1;
    end
    s_rready[m] = 1'b0;
  endtask

  task automatic idle_masters();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    for (int i = 0; i < 2; i++) begin
      s_awid[i] = '0; s_awaddr[i] = '0; s_awlen[i] = '0; s_awsize[i] = '0; s_awburst[i] = '0;
      s_arid[i] = '0; s_araddr[i] = '0; s_arlen[i] = '0; s_arsize[i] = '0; s_arburst[i] = '0;
      s_wdata[i] = '0; s_wstrb[i] = '0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [63:0] base;
    logic [7:0]  strb;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i0, n;
    vecs[0] = '{1, 1'b1, 32'h0800, 8'd1, 64'hA5A5_0000_0000_0001, 8'hFF, 1'b1};
    vecs[1] = '{0, 1'b0, 32'h0800, 8'd1, 64'h0,                   8'h00, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h0808, 8'd0, 64'h0000_0000_DEAD_0000, 8'h0C, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h0800, 8'd1, 64'h0,                   8'h00, 1'b1};
    vecs[4] = '{1, 1'b1, 32'h0100, 8'd0, 64'h5555_6666_7777_8888, 8'hF0, 1'b1};
    vecs[5] = '{0, 1'b0, 32'h0100, 8'd3, 64'h0,                   8'h00, 1'b0};

    idle_masters();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle ctl cycle %0d", c), 64'(ctl_vec()), 64'h0);
    end

    // 2: single S0 burst, S1 must stay quiet
    n = s1_act_cnt;
    @(posedge clk); #1;
    do_write(0, 32'h0100, 8'd3, 64'h11, 8'hFF, 6'h01);
    for (int k = 0; k < 4; k++)
      check($sformatf("ram beat %0d", k), ram[13'h20 + 13'(k)], 64'h11 * 64'(k + 1));
    check("s1 quiet during s0 write", 64'(s1_act_cnt - n), 64'h0);

    // 3: simultaneous reads, S0 wins the first tie after reset
    do_write(1, 32'h0200, 8'd0, 64'h0202_0202_0202_0202, 8'hFF, 6'h02);
    do_write(0, 32'h0300, 8'd0, 64'h0303_0303_0303_0303, 8'hFF, 6'h03);
    i0 = rd_log.size();
    fork
      do_read(0, 32'h0200, 8'd0, 6'h0A);
      do_read(1, 32'h0300, 8'd0, 6'h1B);
    join
    check("rd tie count", 64'(rd_log.size() - i0), 64'd2);
    if (rd_log.size() - i0 == 2) begin
      check("rd tie first", 64'(rd_log[i0]), 64'd0);
      check("rd tie second", 64'(rd_log[i0 + 1]), 64'd1);
    end

    // table vectors: single-master bursts incl. partial strobes and len=0
    foreach (vecs[v]) begin
      i0 = vecs[v].wr ? wr_log.size() : rd_log.size();
      if (vecs[v].wr) do_write(vecs[v].m, vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].strb, 6'(v));
      else            do_read(vecs[v].m, vecs[v].addr, vecs[v].len, 6'(v + 8));
      if (vecs[v].wr) check($sformatf("vec %0d wr gnt", v), 64'(wr_log[i0]), 64'(vecs[v].exp_gnt));
      else            check($sformatf("vec %0d rd gnt", v), 64'(rd_log[i0]), 64'(vecs[v].exp_gnt));
    end

    // 4: contending back-to-back writes must alternate
    i0 = wr_log.size();
    begin
      logic first;
      first = wr_pref;
      fork
        for (int k = 0; k < 8; k++) do_write(0, 32'h4000 + 32'(k * 16), 8'd1, 64'h4000 + 64'(k), 8'hFF, 6'h10);
        for (int k = 0; k < 8; k++) do_write(1, 32'h4800 + 32'(k * 16), 8'd1, 64'h4800 + 64'(k), 8'hFF, 6'h11);
      join
      check("wr alternation count", 64'(wr_log.size() - i0), 64'd16);
      for (int k = 0; k < 16 && i0 + k < wr_log.size(); k++)
        check($sformatf("wr alternation %0d", k), 64'(wr_log[i0 + k]), 64'(first ^ k[0]));
    end
    do_read(0, 32'h4000, 8'd1, 6'h12);
    do_read(1, 32'h4870, 8'd1, 6'h13);

    // 5: read and write directions in flight together
    do_write(0, 32'h1000, 8'd7, 64'h1000_0000_0000_0101, 8'hFF, 6'h20);
    n = overlap_cnt;
    fork
      do_read(0, 32'h1000, 8'd7, 6'h21);
      do_write(1, 32'h2000, 8'd7, 64'h2000_0000_0000_0303, 8'hFF, 6'h22);
    join
    check("wr/rd overlap seen", 64'(overlap_cnt - n > 0), 64'd1);
    do_read(1, 32'h2000, 8'd7, 6'h23);

    // 6: reset in the middle of a write burst; leave pointer preferring S1 beforehand
    do_write(0, 32'h5000, 8'd0, 64'h5000, 8'hFF, 6'h30);
    s_awid[0] = 6'h31; s_awaddr[0] = 32'h6000; s_awlen[0] = 8'd3; s_awsize[0] = 3'd3; s_awburst[0] = 2'd1;
    s_awvalid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready[0] && n < TMO);
    if (!s_awready[0]) timeout("rst aw");
    @(posedge clk); #1 s_awvalid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_wdata[0] = 64'h6000 + 64'(k); s_wstrb[0] = 8'hFF; s_wlast[0] = 1'b0; s_wvalid[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_wready[0] && n < TMO);
      if (!s_wready[0]) timeout("rst w");
      if (k < 2) begin @(posedge clk); #1; end
    end
    check("busy before reset", 64'(o_wr_busy), 64'd1);
    #2 rstn = 1'b0;
    #1 check("async reset ctl", 64'(ctl_vec()), 64'h0);
    idle_masters();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wr_pref = 1'b0;
    @(negedge clk);
    check("post reset ctl", 64'(ctl_vec()), 64'h0);
    @(posedge clk); #1;
    i0 = wr_log.size();
    fork
      do_write(0, 32'h7100, 8'd0, 64'h7100, 8'hFF, 6'h32);
      do_write(1, 32'h7200, 8'd0, 64'h7200, 8'hFF, 6'h33);
    join
    check("post reset tie winner", 64'(wr_log[i0]), 64'd0);
    i0 = wr_log.size();
    do_write(1, 32'h7000, 8'd3, 64'h0707_0000_0000_0001, 8'hFF, 6'h34);
    check("post reset s1 gnt", 64'(wr_log[i0]), 64'd1);
    do_read(1, 32'h7000, 8'd3, 6'h35);
    do_read(0, 32'h7100, 8'd0, 6'h36);

    // global properties
    repeat (2) @(negedge clk);
    check("non-granted master handshake leak", 64'(leak_cnt), 64'd0);
    check("slave protocol errors", 64'(slave_err), 64'd0);
    check("scoreboard drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
